// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and helpers for the I2C register-port arbiter
package i2c_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

  localparam int NUM_REQ_MAX = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker, search starts at ptr and wraps
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/i2c_share_arb.sv
// rtl/i2c_share_arb.sv - shares one I2C peripheral register port among NUM_REQ requesters with lock/timeout
// Define I2C_ARB_IRQ_ROUTE_EN to route irq_i only to the lock owner / last granted requester.
module i2c_share_arb
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    lock_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*4-1:0]  be_i,
  input  logic [NUM_REQ*32-1:0] addr_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rvalid_o,
  output logic [31:0]           rdata_o,
  output logic [NUM_REQ-1:0]    lock_lost_o,
  output logic [NUM_REQ-1:0]    irq_o,
  output logic                  slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [31:0]           slv_rdata_i,
  input  logic                  irq_i
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = (LOCK_TIMEOUT <= 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] lock_lost_q, lock_lost_d;
  logic               rd_pend_q;
  logic [IW-1:0]      rd_id_q;

  logic [NUM_REQ-1:0] cand_req, pick_gnt, gnt, owner_mask;
  logic [IW-1:0]      win_idx;
  logic               pick_valid, win_valid;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    return (k == IDX_LAST) ? '0 : k + 1'b1;
  endfunction

  // While a lock is held only the owner's request is visible to the picker.
  assign owner_mask = ONE << owner_q;
  assign cand_req   = (state_q == ARB_OWNED) ? (req_i & owner_mask) : req_i;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (cand_req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (win_idx),
    .valid (pick_valid)
  );

  assign win_valid = pick_valid & ~rst_i;
  assign gnt       = rst_i ? '0 : pick_gnt;
  assign gnt_o     = gnt;
  assign slv_req_o = win_valid;

  always_comb begin
    slv_we_o    = 1'b0;
    slv_be_o    = '0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        slv_we_o    = we_i[k];
        slv_be_o    = be_i[4*k +: 4];
        slv_addr_o  = addr_i[32*k +: 32];
        slv_wdata_o = wdata_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    lock_lost_d = '0;
    if (win_valid) begin
      rr_ptr_d = next_idx(win_idx);
    end
    case (state_q)
      ARB_IDLE: begin
        if (win_valid && lock_i[win_idx]) begin
          state_d = ARB_OWNED;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      ARB_OWNED: begin
        if (win_valid) begin
          cnt_d = '0;
          if (!lock_i[owner_q]) begin
            state_d = ARB_IDLE;
          end
        end else if (!lock_i[owner_q]) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Owner went quiet too long: free the port and tell it so.
          state_d              = ARB_IDLE;
          cnt_d                = '0;
          rr_ptr_d             = next_idx(owner_q);
          lock_lost_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      lock_lost_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      rd_pend_q   <= win_valid & ~slv_we_o;
      rd_id_q     <= win_idx;
    end
  end

  // The peripheral registers its read data, so it is simply forwarded in the return cycle.
  assign lock_lost_o = lock_lost_q;
  assign rvalid_o    = (rd_pend_q && !rst_i) ? (ONE << rd_id_q) : '0;
  assign rdata_o     = (rd_pend_q && !rst_i) ? slv_rdata_i : '0;

`ifdef I2C_ARB_IRQ_ROUTE_EN
  logic [IW-1:0] last_id_q;
  logic [IW-1:0] irq_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_id_q <= '0;
    end else if (win_valid) begin
      last_id_q <= win_idx;
    end
  end

  assign irq_sel = (state_q == ARB_OWNED) ? owner_q : last_id_q;
  assign irq_o   = irq_i ? (ONE << irq_sel) : '0;
`else
  assign irq_o = {NUM_REQ{irq_i}};
`endif

endmodule
